// File: rtl/uart_pkg.sv
// UART receiver shared definitions: FSM state encodings, default frame/oversampling
// parameters and the counter widths derived from them.
package uart_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OVS_DEF  = 16;
  localparam int SB_TICK_DEF = 16;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int TICK_W_DEF = cnt_w((NB_OVS_DEF > SB_TICK_DEF) ? NB_OVS_DEF : SB_TICK_DEF);
  localparam int BIT_W_DEF  = cnt_w(NB_DATA_DEF);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the idle-high serial line; 2-cycle latency, no backpressure.
// Both flops reset to 1 so a reset never fabricates a falling edge.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (8N1 default; UART_RX_PARITY_EN adds an even-parity bit and o_parity_err).
// Result pulses one cycle after the stop-bit sample; no backpressure, a consumer must take o_rx_data on o_rx_done.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OVS  = NB_OVS_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
`ifdef UART_RX_PARITY_EN
  output logic               o_parity_err,
`endif
  output logic               o_frame_err
);

  localparam int TW = cnt_w((NB_OVS > SB_TICK) ? NB_OVS : SB_TICK);
  localparam int BW = cnt_w(NB_DATA);

  localparam logic [TW-1:0] TICK_HALF = TW'(NB_OVS/2 - 1);
  localparam logic [TW-1:0] TICK_BIT  = TW'(NB_OVS - 1);
  localparam logic [TW-1:0] TICK_STOP = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);

  logic rx_s;

  state_t             state_q;
  logic [TW-1:0]      tick_q;
  logic [BW-1:0]      bit_q;
  logic [NB_DATA-1:0] shift_q;
  logic [NB_DATA-1:0] data_q;
  logic               done_q;
  logic               ferr_q;
`ifdef UART_RX_PARITY_EN
  logic               par_q;
  logic               perr_q;
`endif

  uart_rx_sync u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            tick_q  <= '0;
          end
        end
        START: begin
          if (i_s_tick) begin
            // Mid-start-bit check rejects glitches shorter than half a bit.
            if (tick_q == TICK_HALF) begin
              if (!rx_s) begin
                state_q <= DATA;
                tick_q  <= '0;
                bit_q   <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_s_tick) begin
            if (tick_q == TICK_BIT) begin
              tick_q  <= '0;
              shift_q <= {rx_s, shift_q[NB_DATA-1:1]};
              if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (i_s_tick) begin
            if (tick_q == TICK_BIT) begin
              tick_q  <= '0;
              par_q   <= rx_s;
              state_q <= STOP;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (i_s_tick) begin
            if (tick_q == TICK_STOP) begin
              state_q <= IDLE;
              tick_q  <= '0;
              if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                // A bad stop bit outranks parity; parity only gates a well-framed byte.
                if (par_q != ^shift_q) begin
                  perr_q <= 1'b1;
                end else begin
                  data_q <= shift_q;
                  done_q <= 1'b1;
                end
`else
                data_q <= shift_q;
                done_q <= 1'b1;
`endif
              end else begin
                ferr_q <= 1'b1;
              end
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rx_data   = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected pulses are queued before each frame and matched as the DUT emits them.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLKS = 32;  // 16 ticks per bit, one tick every 2 clocks

  localparam int EV_DONE = 0;
  localparam int EV_FERR = 1;
  localparam int EV_PERR = 2;

  logic       i_clk   = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_rx    = 1'b1;
  logic       i_s_tick;
  logic       tph     = 1'b0;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       perr;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) tph <= ~tph;
  assign i_s_tick = tph;

  uart_rx dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_s_tick     (i_s_tick),
    .i_rx         (i_rx),
    .o_rx_data    (o_rx_data),
    .o_rx_done    (o_rx_done),
`ifdef UART_RX_PARITY_EN
    .o_parity_err (perr),
`endif
    .o_frame_err  (o_frame_err)
  );

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every output pulse must match the head of the queue.
  always @(negedge i_clk) begin
    if (i_reset && (o_rx_done || o_frame_err || perr)) begin
      int   obs_kind;
      exp_t e;
      obs_kind = o_rx_done ? EV_DONE : (o_frame_err ? EV_FERR : EV_PERR);
      check("pulse_exclusive", 32'(o_rx_done) + 32'(o_frame_err) + 32'(perr), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(obs_kind), 32'hFF);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'(obs_kind), 32'(e.kind));
        check("pulse_data", 32'(o_rx_data), 32'(e.data));
      end
    end
  end

  task automatic send_bit(input logic v, input int clks);
    i_rx = v;
    repeat (clks) @(negedge i_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_clks, input logic par_v);
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    send_bit(par_v, BIT_CLKS);
`else
    if (par_v !== ^d) i_rx = 1'b1;
`endif
    send_bit(stop_v, stop_clks);
    i_rx = 1'b1;
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge i_clk);
    check("rst_data", 32'(o_rx_data), 32'h0);
    check("rst_done", 32'(o_rx_done), 32'h0);
    check("rst_ferr", 32'(o_frame_err), 32'h0);
    i_reset = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge i_clk);
    check("idle_state", 32'(dut.state_q), 32'(IDLE));

    // Clean 0xA5
    push(EV_DONE, 8'hA5);
    send_frame(8'hA5, 1'b1, BIT_CLKS, ^8'hA5);
    repeat (2 * BIT_CLKS) @(negedge i_clk);
    check("a5_data", 32'(o_rx_data), 32'hA5);

    // Short glitch: 4 ticks low
    send_bit(1'b0, 8);
    send_bit(1'b1, 2 * BIT_CLKS);
    check("glitch_state", 32'(dut.state_q), 32'(IDLE));
    check("glitch_data", 32'(o_rx_data), 32'hA5);

    // Bad stop bit, held low past the sample point then released
    push(EV_FERR, 8'hA5);
    send_frame(8'h3C, 1'b0, 24, ^8'h3C);
    repeat (3 * BIT_CLKS) @(negedge i_clk);
    check("ferr_data", 32'(o_rx_data), 32'hA5);
    check("ferr_state", 32'(dut.state_q), 32'(IDLE));

    // Back-to-back frames, no idle gap
    push(EV_DONE, 8'h00);
    push(EV_DONE, 8'hFF);
    send_frame(8'h00, 1'b1, BIT_CLKS, ^8'h00);
    send_frame(8'hFF, 1'b1, BIT_CLKS, ^8'hFF);
    repeat (2 * BIT_CLKS) @(negedge i_clk);
    check("b2b_data", 32'(o_rx_data), 32'hFF);

    // Reset in the 4th data bit of 0x55
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) send_bit(1'(8'h55 >> i), BIT_CLKS);
    send_bit(1'b0, BIT_CLKS / 2);
    i_reset = 1'b0;
    i_rx    = 1'b1;
    repeat (4) @(negedge i_clk);
    i_reset = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge i_clk);
    check("abort_data", 32'(o_rx_data), 32'h0);
    check("abort_state", 32'(dut.state_q), 32'(IDLE));

    // 0x81 after the aborted frame; data must stay 0 until its stop bit
    push(EV_DONE, 8'h81);
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) send_bit(1'(8'h81 >> i), BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    send_bit(^8'h81, BIT_CLKS);
`endif
    check("pre81_data", 32'(o_rx_data), 32'h0);
    send_bit(1'b1, BIT_CLKS);
    repeat (2 * BIT_CLKS) @(negedge i_clk);
    check("x81_data", 32'(o_rx_data), 32'h81);

`ifdef UART_RX_PARITY_EN
    push(EV_PERR, 8'h81);
    send_frame(8'h07, 1'b1, BIT_CLKS, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge i_clk);
    check("perr_data", 32'(o_rx_data), 32'h81);
    push(EV_DONE, 8'h07);
    send_frame(8'h07, 1'b1, BIT_CLKS, 1'b1);
    repeat (2 * BIT_CLKS) @(negedge i_clk);
    check("par_ok_data", 32'(o_rx_data), 32'h07);
`endif

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, giving the data bits per frame.
REQ-002 The block SHALL have parameter NB_OVS, default 16, giving the i_s_tick pulses per bit period.
REQ-003 The block SHALL have parameter SB_TICK, default 16, giving the ticks counted for the stop bit.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single system clock; all state updates on the rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port i_s_tick, input, 1 bit: one-cycle pulse from the baud generator at NB_OVS times the baud rate.
REQ-007 The block SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 The block SHALL have port o_rx_data, output, NB_DATA bits: the last correctly received byte, held stable between frames.
REQ-009 The block SHALL have port o_rx_done, output, 1 bit: one-cycle pulse marking a valid new o_rx_data; feeds the command interface's i_rx_done.
REQ-010 The block SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when the sampled stop bit is 0.

Function
REQ-011 i_rx SHALL pass through a 2-FF synchronizer whose flops reset to 1; all further references to the line mean the synchronized value.
REQ-012 The FSM SHALL have exactly four states: IDLE, START, DATA and STOP.
REQ-013 In IDLE, a synchronized line value of 0 SHALL cause a move to START and clear the tick counter; no i_s_tick is needed.
REQ-014 In START, the tick counter SHALL advance only on i_s_tick cycles.
REQ-015 On the tick at which the START counter equals NB_OVS/2-1: if the line is 0, the FSM SHALL move to DATA and clear both the tick counter and the bit counter; if the line is 1, the FSM SHALL return to IDLE (glitch reject) with no output pulse.
REQ-016 In DATA, on the tick at which the counter equals NB_OVS-1, the line SHALL be shifted into the shift register LSB-first (right shift, new bit at the MSB) and the counter cleared.
REQ-017 After NB_DATA DATA samples, the FSM SHALL move to STOP.
REQ-018 In STOP, on the tick at which the counter equals SB_TICK-1, the line SHALL be sampled and the FSM SHALL return to IDLE.
REQ-019 If the STOP sample is 1, o_rx_data SHALL load the shift register and o_rx_done SHALL pulse high for exactly one cycle, in the cycle after the sampling edge.
REQ-020 If the STOP sample is 0, o_frame_err SHALL pulse for one cycle, o_rx_data SHALL remain unchanged, o_rx_done SHALL stay 0, and the FSM SHALL return to IDLE.
REQ-021 If the line is still low on return to IDLE after a frame error, the FSM SHALL treat it as a new start bit.
REQ-022 Back-to-back frames with zero idle bits SHALL both be received: a start edge immediately after STOP is accepted.
REQ-023 i_s_tick pulses SHALL be ignored in IDLE, and line changes SHALL be ignored between sample points.
REQ-024 o_rx_done and o_frame_err SHALL never be high in the same cycle.

Reset
REQ-025 While i_reset=0 at a clock edge, the FSM SHALL go to IDLE, all counters and the shift register SHALL clear to 0, o_rx_data SHALL be 0, o_rx_done and o_frame_err SHALL be 0, and both synchronizer flops SHALL be 1.
REQ-026 A reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL restart only on a fresh high-to-low transition of the synchronized line.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, a PARITY state SHALL be inserted between DATA and STOP that samples one even-parity bit at counter NB_OVS-1.
REQ-028 With UART_RX_PARITY_EN defined, an output o_parity_err (1 bit) SHALL be added; on a parity mismatch with a good stop bit it SHALL pulse in place of o_rx_done, and o_rx_data SHALL not update.
REQ-029 With UART_RX_PARITY_EN defined and a bad stop bit, only o_frame_err SHALL pulse, regardless of parity.
REQ-030 With UART_RX_PARITY_EN undefined, the PARITY state, the parity logic and the o_parity_err port SHALL be absent and the frame SHALL be 8N1.

Structure
REQ-031 Package uart_pkg SHALL hold the state encodings (IDLE, START, DATA, STOP, PARITY), the default NB_DATA, NB_OVS and SB_TICK values, and the counter widths derived from them.
REQ-032 The 2-FF synchronizer SHALL be the single sub-module, uart_rx_sync; everything else SHALL be inline in uart_rx.

Verification
REQ-033 Send 0xA5 in 8N1 with 16 ticks per bit: exactly one o_rx_done pulse, o_rx_data=0xA5, o_frame_err never high.
REQ-034 Drive the line low for 4 ticks, then high: no pulse on any output, FSM back in IDLE, o_rx_data unchanged.
REQ-035 Send 0x3C with stop bit 0: o_frame_err pulses once, o_rx_done stays 0, o_rx_data keeps its prior value 0xA5.
REQ-036 Send 0x00 then 0xFF with no idle gap: two o_rx_done pulses, data values 0x00 then 0xFF in order.
REQ-037 Assert reset in the 4th data bit of 0x55, release, then send 0x81: no pulse for the aborted frame, o_rx_data=0x00 until the 0x81 frame completes, then one pulse with o_rx_data=0x81.
REQ-038 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0: o_parity_err pulses, no o_rx_done; resend with parity bit 1: o_rx_done pulses with o_rx_data=0x07.
